// File: rtl/clock_pkg.sv
// Shared encodings and limits for the clock mode/alarm controller.
package clock_pkg;

  typedef logic [1:0] mode_t;
  typedef logic [1:0] alarm_state_t;

  localparam mode_t MODE_RUN       = 2'd0;
  localparam mode_t MODE_SET_TIME  = 2'd1;
  localparam mode_t MODE_SET_ALARM = 2'd2;

  localparam alarm_state_t AL_IDLE   = 2'd0;
  localparam alarm_state_t AL_RING   = 2'd1;
  localparam alarm_state_t AL_SNOOZE = 2'd2;

  localparam logic [4:0] HOUR_MAX = 5'd23;
  localparam logic [5:0] MIN_MAX  = 6'd59;

endpackage

// File: rtl/switch_debounce.sv
// Raw switch -> 2-flop synchronizer -> debounce counter -> single-cycle press strobe.
// Strobe is registered, DEBOUNCE_CYCLES+2 edges after the raw level first settles high.
module switch_debounce #(
  parameter int DEBOUNCE_CYCLES = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic press
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES) + 1;

  logic          sync_1;
  logic          sync_2;
  logic          level;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_1 <= 1'b0;
      sync_2 <= 1'b0;
      level  <= 1'b0;
      cnt    <= '0;
      press  <= 1'b0;
    end else begin
      sync_1 <= raw;
      sync_2 <= sync_1;
      press  <= 1'b0;
      // Any bounce back to the accepted level restarts the qualification window.
      if (sync_2 == level) begin
        cnt <= '0;
      end else if (cnt == CW'(DEBOUNCE_CYCLES)) begin
        level <= sync_2;
        cnt   <= '0;
        press <= sync_2;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/clock_ctrl.sv
// Mode FSM, alarm registers and alarm ring/snooze FSM driven by three debounced buttons.
// Register effects land one edge after the internal press strobe.
module clock_ctrl
  import clock_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 3,
  parameter int RING_CYCLES     = 500,
  parameter int SNOOZE_CYCLES   = 1000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       switch_1,
  input  logic       switch_2,
  input  logic       switch_3,
  input  logic [4:0] cur_hour,
  input  logic [5:0] cur_min,
  output logic [1:0] mode,
  output logic       time_hold,
  output logic       inc_hour,
  output logic       inc_min,
  output logic [4:0] alarm_hour,
  output logic [5:0] alarm_min,
  output logic       alarm_en,
  output logic       buzzer
);

  localparam int RW = $clog2(RING_CYCLES) + 1;
  localparam int SW = $clog2(SNOOZE_CYCLES) + 1;

  logic         press_1, press_2, press_3;
  logic         s1, s2, s3;
  logic         match, match_q;
  logic         alarm_busy;
  logic         alarm_off;
  alarm_state_t al_state;
  logic [RW-1:0] ring_cnt;
  logic [SW-1:0] snooze_cnt;

  switch_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_1 (.clk(clk), .rst(rst), .raw(switch_1), .press(press_1));
  switch_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_2 (.clk(clk), .rst(rst), .raw(switch_2), .press(press_2));
  switch_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_3 (.clk(clk), .rst(rst), .raw(switch_3), .press(press_3));

  assign s3 = press_3;
  assign s1 = press_1 & ~press_3;
  assign s2 = press_2 & ~press_3 & ~press_1;

  assign match      = alarm_en && (mode == MODE_RUN) &&
                      (cur_hour == alarm_hour) && (cur_min == alarm_min);
  assign alarm_busy = (al_state != AL_IDLE);
  // Acknowledge, or alarm_en being cleared now or already, silences the alarm.
  assign alarm_off  = s3 || (s1 && alarm_en) || !alarm_en;
  assign time_hold  = (mode == MODE_SET_TIME);
  assign buzzer     = (al_state == AL_RING);

  always_ff @(posedge clk) begin
    if (rst) begin
      mode       <= MODE_RUN;
      inc_hour   <= 1'b0;
      inc_min    <= 1'b0;
      alarm_hour <= '0;
      alarm_min  <= '0;
      alarm_en   <= 1'b0;
    end else begin
      inc_hour <= 1'b0;
      inc_min  <= 1'b0;
      case (mode)
        MODE_RUN: begin
          if (s3 && !alarm_busy) mode <= MODE_SET_TIME;
          else if (s1)           alarm_en <= ~alarm_en;
        end
        MODE_SET_TIME: begin
          if (s3) mode <= MODE_SET_ALARM;
          inc_hour <= s1;
          inc_min  <= s2;
        end
        MODE_SET_ALARM: begin
          if (s3) mode <= MODE_RUN;
          if (s1) alarm_hour <= (alarm_hour == HOUR_MAX) ? 5'd0 : alarm_hour + 5'd1;
          if (s2) alarm_min  <= (alarm_min == MIN_MAX) ? 6'd0 : alarm_min + 6'd1;
        end
        default: mode <= MODE_RUN;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      al_state   <= AL_IDLE;
      match_q    <= 1'b0;
      ring_cnt   <= '0;
      snooze_cnt <= '0;
    end else begin
      match_q <= match;
      case (al_state)
        AL_IDLE: begin
          if (match && !match_q) begin
            al_state <= AL_RING;
            ring_cnt <= '0;
          end
        end
        AL_RING: begin
          if (alarm_off) begin
            al_state <= AL_IDLE;
          end else if (s2) begin
            al_state   <= AL_SNOOZE;
            snooze_cnt <= '0;
          end else if (ring_cnt == RW'(RING_CYCLES - 1)) begin
            al_state <= AL_IDLE;
          end else begin
            ring_cnt <= ring_cnt + RW'(1);
          end
        end
        AL_SNOOZE: begin
          if (alarm_off) begin
            al_state <= AL_IDLE;
          end else if (snooze_cnt == SW'(SNOOZE_CYCLES - 1)) begin
            al_state <= AL_RING;
            ring_cnt <= '0;
          end else begin
            snooze_cnt <= snooze_cnt + SW'(1);
          end
        end
        default: al_state <= AL_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_clock_ctrl.sv
// Scoreboard bench for clock_ctrl: stimulus pushes expected output events, a monitor pops them.
module tb_clock_ctrl;

  localparam int DEB    = 3;
  localparam int RING   = 500;
  localparam int SNOOZE = 1000;

  localparam int K_MODE = 0, K_EN = 1, K_AH = 2, K_AM = 3, K_INCH = 4, K_INCM = 5, K_BUZ = 6;

  typedef struct {
    int kind;
    int val;
    int cyc;
  } ev_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       switch_1, switch_2, switch_3;
  logic [4:0] cur_hour;
  logic [5:0] cur_min;
  logic [1:0] mode;
  logic       time_hold, inc_hour, inc_min, alarm_en, buzzer;
  logic [4:0] alarm_hour;
  logic [5:0] alarm_min;

  clock_ctrl #(
    .DEBOUNCE_CYCLES(DEB),
    .RING_CYCLES(RING),
    .SNOOZE_CYCLES(SNOOZE)
  ) dut (
    .clk(clk), .rst(rst),
    .switch_1(switch_1), .switch_2(switch_2), .switch_3(switch_3),
    .cur_hour(cur_hour), .cur_min(cur_min),
    .mode(mode), .time_hold(time_hold), .inc_hour(inc_hour), .inc_min(inc_min),
    .alarm_hour(alarm_hour), .alarm_min(alarm_min), .alarm_en(alarm_en), .buzzer(buzzer)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int    n_checks = 0;
  int    n_pass   = 0;
  ev_t   exp_q[$];
  string names[7] = '{"mode", "alarm_en", "alarm_hour", "alarm_min", "inc_hour", "inc_min", "buzzer"};

  // Reference model: clock face state at the level of the front-panel rules.
  int m_mode  = 0;
  int m_en    = 0;
  int m_ah    = 0;
  int m_am    = 0;
  int m_alarm = 0;  // 0 quiet, 1 ringing, 2 snoozing

  task automatic check(input string name, input int act, input int req);
    n_checks++;
    if (act == req) n_pass++;
    else $display("FAIL %s: got %0d, required %0d", name, act, req);
  endtask

  function automatic void push(input int k, input int v, input int c);
    ev_t e;
    e.kind = k; e.val = v; e.cyc = c;
    exp_q.push_back(e);
  endfunction

  task automatic observe(input int kind, input int val);
    ev_t e;
    n_checks++;
    if (exp_q.size() == 0) begin
      $display("FAIL unexpected event %s=%0d at cycle %0d", names[kind], val, cyc);
    end else begin
      e = exp_q.pop_front();
      if (e.kind == kind && e.val == val && e.cyc == cyc) n_pass++;
      else $display("FAIL event: got %s=%0d at cycle %0d, required %s=%0d at cycle %0d",
                    names[kind], val, cyc, names[e.kind], e.val, e.cyc);
    end
  endtask

  // Monitor: every output change or strobe is an event that must match the queue head.
  logic       mon_on = 1'b0;
  logic [2:0] p_mode;
  logic       p_en, p_buz;
  logic [4:0] p_ah;
  logic [5:0] p_am;

  always @(negedge clk) begin
    if (mon_on) begin
      if ({time_hold, mode} != p_mode) observe(K_MODE, int'({time_hold, mode}));
      if (alarm_en != p_en)            observe(K_EN, int'(alarm_en));
      if (alarm_hour != p_ah)          observe(K_AH, int'(alarm_hour));
      if (alarm_min != p_am)           observe(K_AM, int'(alarm_min));
      if (inc_hour)                    observe(K_INCH, 1);
      if (inc_min)                     observe(K_INCM, 1);
      if (buzzer != p_buz)             observe(K_BUZ, int'(buzzer));
    end
    p_mode = {time_hold, mode};
    p_en   = alarm_en;
    p_ah   = alarm_hour;
    p_am   = alarm_min;
    p_buz  = buzzer;
  end

  // Expected consequence of a qualified press; only the highest-priority switch counts.
  task automatic model_press(input logic [2:0] m, input int eff);
    if (m[2]) begin
      if (m_alarm != 0) begin
        if (m_alarm == 1) push(K_BUZ, 0, eff);
        m_alarm = 0;
      end else begin
        m_mode = (m_mode + 1) % 3;
        push(K_MODE, (m_mode == 1) ? 4 + m_mode : m_mode, eff);
      end
    end else if (m[0]) begin
      case (m_mode)
        0: begin
          m_en = 1 - m_en;
          push(K_EN, m_en, eff);
          if (m_en == 0 && m_alarm != 0) begin
            if (m_alarm == 1) push(K_BUZ, 0, eff);
            m_alarm = 0;
          end
        end
        1: push(K_INCH, 1, eff);
        default: begin
          m_ah = (m_ah + 1) % 24;
          push(K_AH, m_ah, eff);
        end
      endcase
    end else if (m[1]) begin
      case (m_mode)
        0: if (m_alarm == 1) begin
          push(K_BUZ, 0, eff);
          push(K_BUZ, 1, eff + SNOOZE);
        end
        1: push(K_INCM, 1, eff);
        default: begin
          m_am = (m_am + 1) % 60;
          push(K_AM, m_am, eff);
        end
      endcase
    end
  endtask

  // m = {switch_3, switch_2, switch_1}; held for len cycles, then released long enough to settle.
  task automatic press(input logic [2:0] m, input int len);
    int d;
    @(negedge clk);
    d = cyc;
    {switch_3, switch_2, switch_1} = m;
    if (len >= 2 + DEB) model_press(m, d + 4 + DEB);
    repeat (len) @(negedge clk);
    {switch_3, switch_2, switch_1} = 3'b000;
    repeat (DEB + 6 + $urandom_range(0, 4)) @(negedge clk);
  endtask

  function automatic int plen();
    return $urandom_range(2 + DEB, 2 + DEB + 3);
  endfunction

  task automatic start_ring();
    int c;
    @(negedge clk);
    cur_hour = 5'd6; cur_min = 6'd31;
    repeat (5) @(negedge clk);
    c = cyc;
    cur_min = 6'd30;
    push(K_BUZ, 1, c + 1);
    m_alarm = 1;
  endtask

  initial begin
    #(10 * 60000);
    $display("FAIL watchdog: simulation exceeded cycle budget");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    {switch_3, switch_2, switch_1} = 3'b000;
    cur_hour = 5'($urandom_range(7, 23));
    cur_min  = 6'($urandom_range(0, 59));
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("reset mode", int'(mode), 0);
    check("reset time_hold", int'(time_hold), 0);
    check("reset alarm_en", int'(alarm_en), 0);
    check("reset alarm_hour", int'(alarm_hour), 0);
    check("reset alarm_min", int'(alarm_min), 0);
    check("reset buzzer", int'(buzzer), 0);
    check("reset inc_hour", int'(inc_hour), 0);
    check("reset inc_min", int'(inc_min), 0);
    mon_on = 1'b1;

    // Full mode cycle, then into SET_TIME.
    repeat (4) press(3'b100, plen());

    // Short pulse is lost; a 5-cycle press gives exactly one inc_hour.
    press(3'b001, 2);
    press(3'b001, 2 + DEB);
    for (int i = 0; i < 6; i++) press(($urandom_range(0, 1) != 0) ? 3'b001 : 3'b010, plen());
    press(3'b011, plen());

    // SET_ALARM: climb to 23:59, wrap to 00:00, then set 06:30.
    press(3'b100, plen());
    for (int i = 0; i < 23; i++) press(3'b001, plen());
    for (int i = 0; i < 59; i++) press(3'b010, plen());
    press(3'b001, plen());
    press(3'b010, plen());
    for (int i = 0; i < 6; i++)  press(3'b001, plen());
    for (int i = 0; i < 30; i++) press(3'b010, plen());

    press(3'b100, plen());
    press(3'b001, plen());

    // Ring timeout, no retrigger while the time keeps matching.
    start_ring();
    push(K_BUZ, 0, cyc + 1 + RING);
    m_alarm = 0;
    repeat (RING + 150) @(negedge clk);

    // Snooze, re-ring, then acknowledge.
    start_ring();
    repeat ($urandom_range(20, 200)) @(negedge clk);
    press(3'b010, plen());
    repeat (SNOOZE + $urandom_range(10, 100)) @(negedge clk);
    press(3'b100, plen());
    repeat (50) @(negedge clk);

    // Disabling the alarm mid-ring silences it.
    start_ring();
    repeat ($urandom_range(10, 100)) @(negedge clk);
    press(3'b001, plen());
    @(negedge clk);
    cur_hour = 5'($urandom_range(7, 23));
    press(3'b001, plen());

    // switch_3 beats switch_1 on the same edge.
    press(3'b101, plen());

    // Back to RUN, ring, and reset mid-ring.
    press(3'b100, plen());
    press(3'b100, plen());
    start_ring();
    repeat (30) @(negedge clk);
    mon_on = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    check("buzzer after reset mid-ring", int'(buzzer), 0);
    check("alarm_en after reset mid-ring", int'(alarm_en), 0);
    rst = 1'b0;

    check("scoreboard events left over", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/clock_ctrl.md
# clock_ctrl

Mode and alarm controller for the digital clock. Turns the three front-panel switches into debounced single-cycle commands, runs the mode state machine (run / set time / set alarm), and issues increment strobes to the timekeeping datapath. It holds the alarm time and alarm enable, and drives `buzzer` with ring, snooze and acknowledge behaviour. It sits between the raw `switch_*` inputs and the hour/minute counters of `clock`.

## Interface
- `DEBOUNCE_CYCLES`, default 3: consecutive synchronized cycles a switch must hold a new level before the change is accepted.
- `RING_CYCLES`, default 500: cycles `buzzer` stays high per ring.
- `SNOOZE_CYCLES`, default 1000: cycles from snooze to re-ring.
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `switch_1` in 1: hour / alarm-enable button, asynchronous and raw.
- `switch_2` in 1: minute / snooze button, asynchronous and raw.
- `switch_3` in 1: mode / acknowledge button, asynchronous and raw.
- `cur_hour` in 5: current hour from the datapath, 0–23.
- `cur_min` in 6: current minute from the datapath, 0–59.
- `mode` out 2: 0 = RUN, 1 = SET_TIME, 2 = SET_ALARM.
- `time_hold` out 1: high in SET_TIME; the datapath freezes its seconds count.
- `inc_hour` out 1: one-cycle strobe; the datapath increments the hour, wrapping 23→0.
- `inc_min` out 1: one-cycle strobe; the datapath increments the minute, wrapping 59→0, with no hour carry.
- `alarm_hour` out 5: alarm hour register.
- `alarm_min` out 6: alarm minute register.
- `alarm_en` out 1: alarm armed.
- `buzzer` out 1: alarm sound.

## Operation
- Each switch passes through a 2-flop synchronizer and then a debounce counter.
- A press strobe fires once when the debounced level goes 0→1. Holding the switch gives no repeat.
- A release is also only accepted after `DEBOUNCE_CYCLES` cycles low.
- Strobe priority within one cycle is `switch_3` > `switch_1` > `switch_2`. A lower-priority strobe in the same cycle is discarded.
- Mode FSM:
  - RUN → SET_TIME on `switch_3`, unless ringing or snoozing.
  - SET_TIME → SET_ALARM on `switch_3`.
  - SET_ALARM → RUN on `switch_3`.
  - Encoding 3 is illegal and recovers to RUN on the next cycle.
- RUN: `switch_1` toggles `alarm_en`; `switch_2` is ignored unless ringing.
- SET_TIME: `switch_1` pulses `inc_hour` and `switch_2` pulses `inc_min`.
- SET_ALARM: `switch_1` increments `alarm_hour`, wrapping 23→0; `switch_2` increments `alarm_min`, wrapping 59→0.
- Alarm FSM states: IDLE, RING, SNOOZE.
  - Match = `alarm_en` and mode RUN and `cur_hour==alarm_hour` and `cur_min==alarm_min`.
  - IDLE → RING only on the rising edge of match, i.e. match_q was 0. The alarm therefore rings at most once per matching minute unless snoozed.
  - RING: `buzzer`=1 and the ring counter counts.
  - RING → IDLE when the ring counter reaches `RING_CYCLES`, or on `switch_3` (acknowledge).
  - RING → SNOOZE on `switch_2`; the snooze counter loads 0.
  - SNOOZE → RING when the snooze counter reaches `SNOOZE_CYCLES`; the ring counter restarts from 0.
  - SNOOZE → IDLE on `switch_3`, or when `alarm_en` is cleared.
  - In RING/SNOOZE, `switch_3` acts as acknowledge only, with no mode change. `switch_1` still toggles `alarm_en`; clearing it forces IDLE with `buzzer`=0 on the next cycle.
- Reset values: mode RUN, `alarm_en` 0, alarm 00:00, alarm FSM IDLE, match_q 0, counters 0, and all strobes and `buzzer` 0. The synchronizer and debounce state clear to "released".

## Timing
- A switch that goes high before edge k and stays high produces its internal strobe at edge k+2+`DEBOUNCE_CYCLES`.
- The registered effect (`inc_*` pulse, `mode` change, alarm register update, `alarm_en` toggle) is visible after edge k+3+`DEBOUNCE_CYCLES`.
- Presses shorter than 2+`DEBOUNCE_CYCLES` cycles can be lost.
- `inc_hour` and `inc_min` are exactly 1 cycle wide and never asserted together.
- Match is evaluated on registered inputs. `buzzer` rises 1 cycle after the first cycle match is true.
- Ring length is exactly `RING_CYCLES` cycles. Snooze gap is exactly `SNOOZE_CYCLES` cycles with `buzzer` low.
- `rst` mid-ring drops `buzzer` on the next edge. `rst` mid-debounce discards the press.
- Counter widths are `$clog2` of each parameter, plus 1 bit.

## Structure
- `clock_pkg` holds:
  - mode encodings RUN / SET_TIME / SET_ALARM;
  - alarm state encodings;
  - the constants HOUR_MAX=23 and MIN_MAX=59.
- Sub-module `switch_debounce` (synchronizer, counter and press strobe) is instantiated three times.
- The mode FSM, alarm registers and alarm FSM live in `clock_ctrl`.

## Test plan
- Reset → `mode`=0, `alarm_en`=0, alarm 00:00, `buzzer`=0.
- Test with `DEBOUNCE_CYCLES`=3 throughout:
  - **Debounce.** `switch_1` high 2 cycles, low, then high 5 cycles in SET_TIME → no `inc_hour` for the 2-cycle pulse, exactly one `inc_hour` at 6 cycles after the 5-cycle press begins.
  - **Mode cycle.** 3 `switch_3` presses → mode 1, 2, 0. `time_hold` is high only in mode 1.
  - **Alarm set with wrap.** In SET_ALARM with `alarm_hour`=23 and `alarm_min`=59, press `switch_1` and `switch_2` → alarm 00:00.
  - **Ring and timeout.** `alarm_en`=1, alarm 06:30, drive `cur_hour`=6, `cur_min`=30 → `buzzer` high for exactly 500 cycles, then low and does not retrigger while the inputs stay at 06:30.
  - **Snooze, then acknowledge.** `switch_2` during ring → `buzzer` low for 1000 cycles, then high again. `switch_3` then → `buzzer` low, `mode` still 0.
  - **Simultaneous presses.** `switch_3` and `switch_1` pressed on the same edge in RUN → mode goes to SET_TIME and `alarm_en` is unchanged.
